// File: rtl/fp_pkg.sv
// -----------------------------------------------------------------------------
// fp_pkg
// Shared float32 definitions used by the fixed-to-float converter and the
// float arithmetic units of the BP network datapath.
//
// Contents:
//   FP_EXP_BIAS / FP_EXP_W / FP_MANT_W : IEEE-754 single-precision field layout
//   fp32_t                              : packed {sign, exp, mant} view of a float32
//   FP_ZERO                             : canonical positive zero
//   fp_pack()                           : assemble a float32 word from its fields
// -----------------------------------------------------------------------------
package fp_pkg;

  localparam int FP_EXP_BIAS = 127;
  localparam int FP_MANT_W   = 23;
  localparam int FP_EXP_W    = 8;

  localparam logic [31:0] FP_ZERO = 32'h0000_0000;

  typedef struct packed {
    logic                 sign;
    logic [FP_EXP_W-1:0]  exp;
    logic [FP_MANT_W-1:0] mant;
  } fp32_t;

  function automatic fp32_t fp_pack(input logic                 sign,
                                    input logic [FP_EXP_W-1:0]  exp,
                                    input logic [FP_MANT_W-1:0] mant);
    fp32_t f;
    f.sign = sign;
    f.exp  = exp;
    f.mant = mant;
    return f;
  endfunction

endpackage

// File: rtl/u_lzc.sv
// -----------------------------------------------------------------------------
// u_lzc
// Combinational leading-zero counter.
//
// Parameters:
//   W  : input width
//   CW : count width, wide enough to hold the value W (all-zero input)
//
// Ports:
//   data_i  [W-1:0]  word to scan, MSB first
//   count_o [CW-1:0] number of zero bits above the most significant one;
//                    equals W when data_i is zero
// -----------------------------------------------------------------------------
module u_lzc #(
  parameter int W  = 32,
  parameter int CW = $clog2(W + 1)
) (
  input  logic [W-1:0]  data_i,
  output logic [CW-1:0] count_o
);

  // Scan from LSB upward; the last set bit seen is the most significant one,
  // so its assignment is the one that survives.
  always_comb begin
    count_o = CW'(W);
    for (int i = 0; i < W; i++) begin
      if (data_i[i]) begin
        count_o = CW'(W - 1 - i);
      end
    end
  end

endmodule

// File: rtl/u_fix2float.sv
// -----------------------------------------------------------------------------
// u_fix2float
// Three-stage pipelined converter from signed fixed-point
// Q(IN_W-FRAC_W).FRAC_W to IEEE-754 single precision, round to nearest even.
//
//   S1 : sign / magnitude
//   S2 : leading-zero count, normalise, exponent
//   S3 : round, pack into q
//
// Parameters:
//   IN_W   : input width, 8..64
//   FRAC_W : fractional bits, 0..IN_W-1
//
// Ports:
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset
//   din        fixed-point sample (two's complement)
//   in_valid   din valid this cycle
//   in_ready   converter accepts din this cycle
//   q          float32 result {sign, exp[7:0], mant[22:0]}
//   out_valid  q valid
//   out_ready  downstream accepts q
// -----------------------------------------------------------------------------
module u_fix2float
  import fp_pkg::*;
#(
  parameter int IN_W   = 32,
  parameter int FRAC_W = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [IN_W-1:0] din,
  input  logic            in_valid,
  output logic            in_ready,
  output logic [31:0]     q,
  output logic            out_valid,
  input  logic            out_ready
);

  localparam int LZ_W   = $clog2(IN_W + 1);
  localparam int KEEP_W = FP_MANT_W + 1;  // mantissa plus the implicit one

  // Unbiased exponent of a value whose MSB sits at bit IN_W-1, plus bias.
  localparam logic signed [8:0] EXP_BASE = 9'(IN_W - 1 - FRAC_W + FP_EXP_BIAS);

  generate
    if (IN_W < 8 || IN_W > 64) begin : g_bad_in_w
      $error("u_fix2float: IN_W must be in 8..64");
    end
    if (FRAC_W < 0 || FRAC_W > IN_W - 1) begin : g_bad_frac_w
      $error("u_fix2float: FRAC_W must be in 0..IN_W-1");
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Handshake: a single advance enable en = out_ready | ~out_valid moves the
  // whole pipeline. in_ready = en. A sample enters on in_valid & in_ready and
  // leaves on out_valid & out_ready. With en low every stage holds data and
  // valid, so q/out_valid are stable while stalled. Valid flags shift with en,
  // so bubbles travel through; data in an invalid stage is don't-care.
  // ---------------------------------------------------------------------------
  logic en;
  assign en       = out_ready | ~out_valid;
  assign in_ready = en;

  logic v1_q, v2_q, v3_q;

  // ---------------------------------------------------------------------------
  // S1: sign / magnitude
  // ---------------------------------------------------------------------------
  logic            s1_sign_d, s1_sign_q;
  logic [IN_W-1:0] s1_mag_d,  s1_mag_q;

  // Negation in IN_W bits maps the most negative input onto 2^(IN_W-1),
  // which is exactly its magnitude as an unsigned number.
  always_comb begin
    s1_sign_d = din[IN_W-1];
    s1_mag_d  = din[IN_W-1] ? -din : din;
  end

  // ---------------------------------------------------------------------------
  // S2: normalise
  // ---------------------------------------------------------------------------
  logic [LZ_W-1:0]   s1_lz;
  logic              s2_sign_d, s2_sign_q;
  logic [IN_W-1:0]   s2_norm_d, s2_norm_q;
  logic signed [8:0] s2_exp_d,  s2_exp_q;
  logic              s2_zero_d, s2_zero_q;
  logic signed [8:0] lz_s;

  u_lzc #(
    .W  (IN_W),
    .CW (LZ_W)
  ) u_lzc_s2 (
    .data_i  (s1_mag_q),
    .count_o (s1_lz)
  );

  always_comb begin
    lz_s      = 9'(s1_lz);
    s2_sign_d = s1_sign_q;
    s2_norm_d = s1_mag_q << s1_lz;
    s2_exp_d  = EXP_BASE - lz_s;
    s2_zero_d = (s1_mag_q == '0);
  end

  // ---------------------------------------------------------------------------
  // S3: round and pack
  // ---------------------------------------------------------------------------
  // Padding with KEEP_W zeros below the normalised value lets one set of
  // slices serve every IN_W: for IN_W <= 24 guard and sticky land in the
  // padding and are zero, i.e. the conversion is exact.
  logic [IN_W+KEEP_W-1:0] norm_ext;
  logic [KEEP_W-1:0]      kept;
  logic                   guard_bit;
  logic                   sticky_bit;
  logic                   round_up;
  logic [FP_MANT_W:0]     mant_sum;
  logic                   mant_carry;
  logic [FP_MANT_W-1:0]   s3_mant;
  logic signed [8:0]      s3_exp_rnd;
  logic [31:0]            q_d, q_q;

  always_comb begin
    norm_ext   = {s2_norm_q, KEEP_W'(0)};
    kept       = norm_ext[IN_W+KEEP_W-1 -: KEEP_W];
    guard_bit  = norm_ext[IN_W-1];
    sticky_bit = |norm_ext[IN_W-2:0];
    round_up   = guard_bit & (sticky_bit | kept[0]);

    // Only the stored mantissa bits are incremented; a carry out of them with
    // the implicit one set means the rounded value reached the next power of 2.
    mant_sum   = {1'b0, kept[FP_MANT_W-1:0]} + KEEP_W'(round_up);
    mant_carry = mant_sum[FP_MANT_W] & kept[FP_MANT_W];
    s3_mant    = mant_carry ? '0 : mant_sum[FP_MANT_W-1:0];
    s3_exp_rnd = mant_carry ? (s2_exp_q + 9'sd1) : s2_exp_q;

    // Zero is always packed as positive zero, whatever the sign stage saw.
    if (s2_zero_q) begin
      q_d = FP_ZERO;
    end else begin
      q_d = fp_pack(s2_sign_q, s3_exp_rnd[FP_EXP_W-1:0], s3_mant);
    end
  end

  // The exponent of a nonzero result must stay in the normal range 1..254.
  always_ff @(posedge clk) begin
    if (rst_n && v2_q && !s2_zero_q) begin
      assert (s3_exp_rnd > 9'sd0 && s3_exp_rnd < 9'sd255);
    end
  end

  // ---------------------------------------------------------------------------
  // Pipeline registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_q      <= 1'b0;
      v2_q      <= 1'b0;
      v3_q      <= 1'b0;
      s1_sign_q <= 1'b0;
      s1_mag_q  <= '0;
      s2_sign_q <= 1'b0;
      s2_norm_q <= '0;
      s2_exp_q  <= '0;
      s2_zero_q <= 1'b0;
      q_q       <= FP_ZERO;
    end else if (en) begin
      v1_q      <= in_valid;
      v2_q      <= v1_q;
      v3_q      <= v2_q;
      s1_sign_q <= s1_sign_d;
      s1_mag_q  <= s1_mag_d;
      s2_sign_q <= s2_sign_d;
      s2_norm_q <= s2_norm_d;
      s2_exp_q  <= s2_exp_d;
      s2_zero_q <= s2_zero_d;
      q_q       <= q_d;
    end
  end

  assign q         = q_q;
  assign out_valid = v3_q;

endmodule

// File: tb/tb_u_fix2float.sv
// -----------------------------------------------------------------------------
// tb_u_fix2float
// Directed, self-checking bench for u_fix2float with default Q16.16 parameters.
// Table of hand-computed vectors, then streaming, backpressure and mid-stream
// reset sequences checked against an arithmetic reference model.
// -----------------------------------------------------------------------------
module tb_u_fix2float;

  logic        clk;
  logic        rst_n;
  logic [31:0] din;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] q;
  logic        out_valid;
  logic        out_ready;

  u_fix2float #(
    .IN_W   (32),
    .FRAC_W (16)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .din       (din),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .q         (q),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  // ---------------------------------------------------------------------------
  // Clock and watchdog
  // ---------------------------------------------------------------------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
    $fatal(1, "watchdog expired");
  end

  // ---------------------------------------------------------------------------
  // Scoreboard state
  // ---------------------------------------------------------------------------
  logic [31:0] exp_q[$];
  int          out_cyc_q[$];
  int          n_checks;
  int          n_errors;
  int          cyc;
  int          n_in;
  int          n_out;
  bit          push_model;

  typedef struct {
    logic [31:0] din;
    logic [31:0] expv;
    string       name;
  } vec_t;

  vec_t vecs[8];

  // Reference: exact integer conversion of the Q16.16 value, rounding by
  // comparing the discarded remainder against one half ulp.
  function automatic logic [31:0] ref_f(input logic [31:0] d);
    longint          v;
    longint unsigned m, keep, rem, half;
    int              p, sh, e;
    logic            s;
    if (d == 32'h0) return 32'h0;
    v = longint'($signed(d));
    s = (v < 0);
    m = s ? longint'(-v) : v;
    p = 63;
    while (m[p] == 1'b0) p--;
    if (p <= 23) begin
      keep = m << (23 - p);
    end else begin
      sh   = p - 23;
      keep = m >> sh;
      rem  = m & ((64'd1 << sh) - 64'd1);
      half = 64'd1 << (sh - 1);
      if (rem > half || (rem == half && keep[0])) keep = keep + 64'd1;
      if (keep == (64'd1 << 24)) begin
        keep = 64'd1 << 23;
        p    = p + 1;
      end
    end
    e = p - 16 + 127;
    return {s, e[7:0], keep[22:0]};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h", name, act, expv);
    end
  endtask

  // One cycle: sample both handshakes 1 ns after the falling edge (inputs and
  // registered outputs are settled and hold until the rising edge), then move
  // to the next falling edge.
  task automatic tick();
    #1;
    if (in_valid && in_ready) begin
      n_in++;
      if (push_model) exp_q.push_back(ref_f(din));
    end
    if (out_valid && out_ready) begin
      n_out++;
      out_cyc_q.push_back(cyc);
      if (exp_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL unexpected_output: got %h, expected no output", q);
      end else begin
        check("scoreboard_q", q, exp_q.pop_front());
      end
    end
    cyc++;
    @(negedge clk);
  endtask

  // Single sample with an idle pipeline: checks latency and (via scoreboard) q.
  task automatic run_vec(input logic [31:0] d, input logic [31:0] expv, input string name);
    int lat;
    din       = d;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    exp_q.push_back(expv);
    tick();
    in_valid = 1'b0;
    lat      = 1;
    while (!out_valid && lat < 10) begin
      tick();
      lat++;
    end
    check({name, "_latency"}, 32'(lat), 32'd3);
    if (!out_valid) exp_q.delete();
    tick();
  endtask

  // ---------------------------------------------------------------------------
  // Test sequence
  // ---------------------------------------------------------------------------
  initial begin
    logic [31:0] stream_din[6];
    int          c0;
    int          in0;
    int          out0;
    int          k;

    n_checks   = 0;
    n_errors   = 0;
    cyc        = 0;
    n_in       = 0;
    n_out      = 0;
    push_model = 1'b0;

    vecs[0] = '{32'h0001_0000, 32'h3F80_0000, "one"};
    vecs[1] = '{32'hFFFF_0000, 32'hBF80_0000, "minus_one"};
    vecs[2] = '{32'h0000_4000, 32'h3E80_0000, "quarter"};
    vecs[3] = '{32'h0000_0000, 32'h0000_0000, "zero"};
    vecs[4] = '{32'h8000_0000, 32'hC700_0000, "most_negative"};
    vecs[5] = '{32'h7FFF_FFFF, 32'h4700_0000, "max_carry"};
    vecs[6] = '{32'h0100_0001, 32'h4380_0000, "tie_even_lsb0"};
    vecs[7] = '{32'h0100_0003, 32'h4380_0002, "tie_even_lsb1"};

    stream_din[0] = 32'h0003_0000;
    stream_din[1] = 32'hFFFE_8000;
    stream_din[2] = 32'h0000_0001;
    stream_din[3] = 32'h1234_5678;
    stream_din[4] = 32'hFFFF_FFFF;
    stream_din[5] = 32'h7FFF_8000;

    // Reset
    rst_n     = 1'b0;
    din       = 32'h0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check("reset_out_valid", {31'b0, out_valid}, 32'd0);
    check("reset_q", q, 32'h0);
    check("reset_in_ready", {31'b0, in_ready}, 32'd1);
    #1 rst_n = 1'b1;
    @(negedge clk);

    // Table-driven single conversions
    for (int i = 0; i < 8; i++) begin
      run_vec(vecs[i].din, vecs[i].expv, vecs[i].name);
    end

    // Back-to-back stream of 6 samples
    push_model = 1'b1;
    out_cyc_q.delete();
    out_ready = 1'b1;
    in_valid  = 1'b1;
    c0        = cyc;
    for (int i = 0; i < 6; i++) begin
      din = stream_din[i];
      tick();
    end
    in_valid = 1'b0;
    k = 0;
    while (exp_q.size() > 0 && k < 20) begin
      tick();
      k++;
    end
    check("stream_out_count", 32'(out_cyc_q.size()), 32'd6);
    for (int i = 0; i < out_cyc_q.size(); i++) begin
      check("stream_out_cycle", 32'(out_cyc_q[i]), 32'(c0 + 3 + i));
    end

    // Backpressure with a full pipeline
    exp_q.delete();
    in0       = n_in;
    out0      = n_out;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    for (int i = 0; i < 4; i++) begin
      din = $urandom_range(32'hFFFF_FFFF, 0);
      tick();
    end
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      din = $urandom_range(32'hFFFF_FFFF, 0);
      #1;
      check("stall_in_ready", {31'b0, in_ready}, 32'd0);
      check("stall_out_valid", {31'b0, out_valid}, 32'd1);
      check("stall_q", q, (exp_q.size() > 0) ? exp_q[0] : 32'hDEAD_BEEF);
      tick();
    end
    out_ready = 1'b1;
    in_valid  = 1'b0;
    k = 0;
    while (exp_q.size() > 0 && k < 20) begin
      tick();
      k++;
    end
    check("stall_queue_drained", 32'(exp_q.size()), 32'd0);
    check("stall_in_out_count", 32'(n_out - out0), 32'(n_in - in0));

    // Asynchronous reset with 3 samples in flight
    exp_q.delete();
    out_ready = 1'b1;
    in_valid  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      din = stream_din[i];
      tick();
    end
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("midreset_out_valid", {31'b0, out_valid}, 32'd0);
    check("midreset_q", q, 32'h0);
    check("midreset_in_ready", {31'b0, in_ready}, 32'd1);
    exp_q.delete();
    @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      #1;
      check("postreset_idle", {31'b0, out_valid}, 32'd0);
      tick();
    end
    push_model = 1'b0;
    run_vec(32'h0000_4000, 32'h3E80_0000, "postreset_quarter");
    check("final_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/u_fix2float.md
Name: u_fix2float

Overview:
- Pipelined signed fixed-point to IEEE-754 single-precision converter.
- Produces the float32 operands consumed by u_add and the other float arithmetic units in the BP network datapath, e.g. quantised sensor or weight inputs.
- Valid/ready streaming interface; full throughput of one sample per cycle; fixed 3-cycle latency when not stalled.

Parameters:
- IN_W, 32, fixed-point input width in bits, two's complement; legal range 8..64.
- FRAC_W, 16, number of fractional bits in din; legal range 0..IN_W-1.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- din  input  IN_W  signed fixed-point sample, Q(IN_W-FRAC_W).FRAC_W.
- in_valid  input  1  din is valid this cycle.
- in_ready  output  1  block accepts din this cycle.
- q  output  32  float32 result: sign[31], exponent[30:23] (bias 127), mantissa[22:0].
- out_valid  output  1  q is valid.
- out_ready  input  1  downstream accepts q.

Behaviour:
- Reset, asynchronous and active-low: all stage valid flags = 0, all stage data registers = 0, q = 32'h0, out_valid = 0. in_ready = 1 after reset.
- Handshake:
  - Global advance enable en = out_ready | ~out_valid. in_ready = en (combinational).
  - Input transfer occurs when in_valid & in_ready. Output transfer occurs when out_valid & out_ready.
  - When en = 0, every stage holds its data and valid flag. q and out_valid stay stable while out_valid=1 and out_ready=0.
  - Bubbles propagate: the valid flags shift with en, and data in invalid stages is don't-care.
- Stage 1 (S1), sign/magnitude:
  - s1_sign = din[IN_W-1].
  - s1_mag = |din| as IN_W-bit unsigned. The most negative input gives magnitude 2^(IN_W-1) with no overflow.
- Stage 2 (S2), normalise:
  - lz = leading-zero count of s1_mag (0..IN_W).
  - s2_norm = s1_mag << lz, so bit IN_W-1 is set when nonzero.
  - s2_exp = (IN_W-1-FRAC_W-lz) + 127, computed at 9-bit signed width.
  - s2_zero = (s1_mag == 0).
- Stage 3 (S3), round and pack:
  - Keep the top 24 bits of s2_norm; the implicit 1 is not stored.
  - guard = next bit below the kept bits; sticky = OR of all lower bits. If IN_W ≤ 24, guard = sticky = 0 and the value is exact.
  - Round to nearest, ties to even: increment when guard & (sticky | kept LSB).
  - If the increment carries out of 24 bits, set mantissa = 0 and exponent + 1.
  - q = {sign, exp[7:0], mant[22:0]}.
- Zero input gives q = 32'h00000000 (positive zero, never negative zero).
- Range: for the legal parameter range the exponent always falls within 1..254. No denormal, inf or NaN is ever generated. Parameter bounds are checked at elaboration time.
- Latency is 3 accepted cycles from the input handshake to out_valid, excluding stall cycles. Sustained throughput is 1 per cycle when out_ready = 1.
- Reset mid-operation: all in-flight samples are discarded immediately and no output transfer follows reset deassertion.

Decomposition:
- Shared package fp_pkg (shared with the float arithmetic units):
  - constants FP_EXP_BIAS = 127, FP_MANT_W = 23, FP_EXP_W = 8;
  - typedef of the float32 fields {sign, exp, mant};
  - constant FP_ZERO = 32'h0.
- One sub-module: u_lzc, a parameterised combinational leading-zero counter (width IN_W, output width clog2(IN_W+1)), instantiated in S2.

Test Plan:
- Basic conversions, Q16.16 with out_ready=1:
  - din 32'h00010000 (1.0) -> q 32'h3F800000 after 3 cycles;
  - 32'hFFFF0000 (-1.0) -> 32'hBF800000;
  - 32'h00004000 (0.25) -> 32'h3E800000.
- Zero and extremes:
  - 32'h00000000 -> 32'h00000000;
  - 32'h80000000 (-32768) -> 32'hC7000000;
  - 32'h7FFFFFFF -> rounds with mantissa carry to 32'h47000000.
- Rounding ties:
  - 32'h01000001 (tie, kept LSB 0) -> 32'h43800000;
  - 32'h01000003 (tie, kept LSB 1) -> 32'h43800002.
- Back-to-back stream: drive 6 consecutive samples with in_valid=1 and out_ready=1 -> 6 results on 6 consecutive cycles, in order, first result 3 cycles after the first input.
- Backpressure: hold out_ready=0 for 5 cycles while the pipeline is full.
  - in_ready=0 and q/out_valid stay stable throughout.
  - After out_ready returns to 1, no sample is lost or duplicated; compare against the reference model.
- Reset mid-stream: assert rst_n=0 asynchronously between clock edges while 3 samples are in flight -> out_valid=0 and q=0 immediately; after release, out_valid stays 0 until new input completes 3 cycles later.
